// File: rtl/proc_fl_if.sv
// Per-instruction trace bundle of proc_fl.
// The processor drives it through the master modport and an observer reads it through the slave modport.
interface proc_fl_if;
  logic        trace_val;
  logic [31:0] trace_addr;
  logic [31:0] trace_inst;
  logic [31:0] trace_data;

  modport master (output trace_val, trace_addr, trace_inst, trace_data);
  modport slave  (input  trace_val, trace_addr, trace_inst, trace_data);
endinterface

// File: rtl/proc_fl.sv
// Functional-level TinyRV1 processor: one instruction per cycle from a unified memory M.
// M is indexed by byte address (the word at address A lives in M[A]), so a testbench can preload it hierarchically.
module proc_fl #(
  parameter int unsigned MEM_WORDS = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out0,
  output logic [31:0] out1,
  output logic [31:0] out2,
  proc_fl_if.master   tr
);
  localparam int unsigned AW = $clog2(MEM_WORDS);

  typedef enum logic [3:0] {
    OP_ILL, OP_ADD, OP_ADDI, OP_MUL, OP_LW, OP_SW,
    OP_JAL, OP_JR, OP_BNE, OP_CSRR, OP_CSRW
  } op_e;

  logic [31:0] M [0:MEM_WORDS-1];
  logic [31:0] rf_q [32];
  logic [31:0] pc_q, pc_d;
  logic [31:0] out0_q, out0_d, out1_q, out1_d, out2_q, out2_d;

  logic [31:0] inst, rs1_v, rs2_v, ea;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [11:0] csr;
  logic        pc_ok, ea_ok;
  op_e         op;
  logic        rf_we, mem_we;
  logic [31:0] rf_wdata;

  assign pc_ok = (pc_q < MEM_WORDS);
  assign inst  = pc_ok ? M[pc_q[AW-1:0]] : '0;

  assign opc = inst[6:0];
  assign rd  = inst[11:7];
  assign f3  = inst[14:12];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign f7  = inst[31:25];
  assign csr = inst[31:20];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // x0 is never stored; reads of it are forced to zero here
  assign rs1_v = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_v = (rs2 == 5'd0) ? '0 : rf_q[rs2];

  assign ea    = rs1_v + ((op == OP_SW) ? imm_s : imm_i);
  assign ea_ok = (ea < MEM_WORDS);

  always_comb begin
    op = OP_ILL;
    case (opc)
      7'b0110011: begin
        if (f3 == 3'd0 && f7 == 7'h00)      op = OP_ADD;
        else if (f3 == 3'd0 && f7 == 7'h01) op = OP_MUL;
      end
      7'b0010011: if (f3 == 3'd0) op = OP_ADDI;
      7'b0000011: if (f3 == 3'd2) op = OP_LW;
      7'b0100011: if (f3 == 3'd2) op = OP_SW;
      7'b1101111: op = OP_JAL;
      7'b1100111: if (f3 == 3'd0 && rd == 5'd0 && imm_i == 32'd0) op = OP_JR;
      7'b1100011: if (f3 == 3'd1) op = OP_BNE;
      7'b1110011: begin
        if (f3 == 3'd2 && rs1 == 5'd0 && csr >= 12'hFC2 && csr <= 12'hFC4)
          op = OP_CSRR;
        else if (f3 == 3'd1 && rd == 5'd0 && csr >= 12'h7C2 && csr <= 12'h7C4)
          op = OP_CSRW;
      end
      default: ;
    endcase
    if (!pc_ok) op = OP_ILL;
  end

  always_comb begin
    pc_d     = pc_q + 32'd4;
    out0_d   = out0_q;
    out1_d   = out1_q;
    out2_d   = out2_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    mem_we   = 1'b0;
    case (op)
      OP_ADD:  begin rf_we = 1'b1; rf_wdata = rs1_v + rs2_v; end
      OP_ADDI: begin rf_we = 1'b1; rf_wdata = rs1_v + imm_i; end
      OP_MUL:  begin rf_we = 1'b1; rf_wdata = rs1_v * rs2_v; end
      OP_LW:   if (ea_ok) begin rf_we = 1'b1; rf_wdata = M[ea[AW-1:0]]; end
      OP_SW:   mem_we = ea_ok;
      OP_JAL:  begin rf_we = 1'b1; rf_wdata = pc_q + 32'd4; pc_d = pc_q + imm_j; end
      OP_JR:   pc_d = rs1_v;
      OP_BNE:  if (rs1_v != rs2_v) pc_d = pc_q + imm_b;
      OP_CSRR: begin
        rf_we = 1'b1;
        case (csr)
          12'hFC2: rf_wdata = in0;
          12'hFC3: rf_wdata = in1;
          default: rf_wdata = in2;
        endcase
      end
      OP_CSRW: begin
        case (csr)
          12'h7C2: out0_d = rs1_v;
          12'h7C3: out1_d = rs1_v;
          default: out2_d = rs1_v;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= '0;
      out0_q <= '0;
      out1_q <= '0;
      out2_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out0_q <= out0_d;
      out1_q <= out1_d;
      out2_q <= out2_d;
    end
  end

  // register file and memory are deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (rst && rf_we && rd != 5'd0) rf_q[rd] <= rf_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) M[ea[AW-1:0]] <= rs2_v;
  end

  assign out0 = out0_q;
  assign out1 = out1_q;
  assign out2 = out2_q;

  assign tr.trace_val  = rst;
  assign tr.trace_addr = pc_q;
  assign tr.trace_inst = inst;
  assign tr.trace_data = rf_we ? rf_wdata : 'x;
endmodule

// File: tb/tb_proc_fl.sv
// Scoreboard bench for proc_fl: an ISA-level interpreter predicts every trace record,
// and a negedge monitor compares them with what the processor presents.
module tb_proc_fl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in0, in1, in2, out0, out1, out2;

  proc_fl_if tr ();

  proc_fl #(.MEM_WORDS(65536)) dut (
    .clk(clk), .rst(rst),
    .in0(in0), .in1(in1), .in2(in2),
    .out0(out0), .out1(out1), .out2(out2),
    .tr(tr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, inst, data;
    bit          has_data;
    logic [31:0] o0, o1, o2;
  } rec_t;

  typedef struct {
    int          idx;
    int          fld;
    logic [31:0] exp;
  } spot_t;

  rec_t  sb[$];
  spot_t spots[$];
  int    n_tests = 0, n_fail = 0, n_commit = 0, to_cnt = 0;
  bit    done = 0;

  // reference machine state
  logic [31:0] m_mem [int unsigned];
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;
  logic [31:0] m_out [3];
  logic [31:0] m_in [3];

  function automatic logic [31:0] e_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [31:0] v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] e_r(int f7, int rs2, int rs1, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] i_addi(int rd, int rs1, int imm); return e_i(imm, rs1, 0, rd, 7'h13); endfunction
  function automatic logic [31:0] i_lw(int rd, int rs1, int imm);   return e_i(imm, rs1, 2, rd, 7'h03); endfunction
  function automatic logic [31:0] i_jr(int rs1);                    return e_i(0, rs1, 0, 0, 7'h67); endfunction
  function automatic logic [31:0] i_csrr(int rd, int c);            return e_i(c, 0, 2, rd, 7'h73); endfunction
  function automatic logic [31:0] i_csrw(int c, int rs1);           return e_i(c, rs1, 1, 0, 7'h73); endfunction
  function automatic logic [31:0] i_sw(int rs2, int rs1, int imm);
    logic [31:0] v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'd2, v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] i_bne(int rs1, int rs2, int imm);
    logic [31:0] v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'd1, v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] i_jal(int rd, int imm);
    logic [31:0] v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
  endfunction

  function automatic logic [31:0] mrd(logic [31:0] a);
    return m_mem.exists(a) ? m_mem[a] : 32'd0;
  endfunction

  task automatic put(int unsigned a, logic [31:0] w);
    dut.M[a] <= w;
    m_mem[a] = w;
  endtask

  // Executes one instruction on the reference machine and queues its trace record.
  task automatic model_step();
    logic [31:0] ins, a, b, res, npc, ii, is, ib, ij;
    int   rd, c;
    bit   wr;
    rec_t r;
    ins = mrd(m_pc);
    rd  = int'(ins[11:7]);
    a   = m_rf[ins[19:15]];
    b   = m_rf[ins[24:20]];
    ii  = 32'($signed(ins) >>> 20);
    is  = 32'($signed({ins[31:25], ins[11:7], 20'd0}) >>> 20);
    ib  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'd0}) >>> 19);
    ij  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'd0}) >>> 11);
    c   = int'(ins[31:20]);
    r.addr = m_pc; r.inst = ins;
    r.o0 = m_out[0]; r.o1 = m_out[1]; r.o2 = m_out[2];
    wr = 0; res = 0; npc = m_pc + 4;
    case (ins[6:0])
      7'h33: if (ins[14:12] == 0 && ins[31:25] == 0) begin wr = 1; res = a + b; end
             else if (ins[14:12] == 0 && ins[31:25] == 1) begin wr = 1; res = a * b; end
      7'h13: if (ins[14:12] == 0) begin wr = 1; res = a + ii; end
      7'h03: if (ins[14:12] == 2) begin wr = 1; res = mrd(a + ii); end
      7'h23: if (ins[14:12] == 2) m_mem[a + is] = b;
      7'h6F: begin wr = 1; res = m_pc + 4; npc = m_pc + ij; end
      7'h67: if (ins[14:12] == 0 && rd == 0 && ii == 0) npc = a;
      7'h63: if (ins[14:12] == 1 && a != b) npc = m_pc + ib;
      7'h73: begin
        if (ins[14:12] == 2 && ins[19:15] == 0 && c >= 'hFC2 && c <= 'hFC4) begin
          wr = 1; res = m_in[c - 'hFC2];
        end else if (ins[14:12] == 1 && rd == 0 && c >= 'h7C2 && c <= 'h7C4)
          m_out[c - 'h7C2] = a;
      end
      default: ;
    endcase
    if (wr && rd != 0) m_rf[rd] = res;
    r.data = res; r.has_data = wr;
    sb.push_back(r);
    m_pc = npc;
  endtask

  task automatic set_in(logic [31:0] a, logic [31:0] b, logic [31:0] c);
    in0 = a; in1 = b; in2 = c;
    m_in[0] = a; m_in[1] = b; m_in[2] = c;
  endtask

  task automatic begin_seg();
    m_pc = 0;
    for (int i = 0; i < 3; i++) m_out[i] = 0;
    for (int unsigned a = 0; a < 32'h500; a++) put(a, 32'd0);
  endtask

  task automatic add_spot(int i, int fld, logic [31:0] v);
    spot_t s;
    s.idx = n_commit + i; s.fld = fld; s.exp = v;
    spots.push_back(s);
  endtask

  // Predicts k steps (or until PC reaches end_pc when k==0), runs the DUT, then resets it.
  task automatic run_seg(int k, logic [31:0] end_pc);
    int steps = 0;
    while ((k > 0) ? (steps < k) : (m_pc < end_pc && steps < 500)) begin
      model_step();
      steps++;
    end
    @(posedge clk); #1 rst = 1'b1;
    for (int c = 0; c < steps + 20 && sb.size() != 0; c++) @(posedge clk);
    if (sb.size() != 0) begin
      to_cnt++;
      sb.delete();
      spots.delete();
    end
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (commit %0d)", nm, act, exp, n_commit);
    end
  endtask

  // monitor / scoreboard checker
  initial begin
    bit   was_rst;
    rec_t e;
    was_rst = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("sb_drained", 32'(sb.size()), 0);
        chk("spots_drained", 32'(spots.size()), 0);
        chk("timeouts", 32'(to_cnt), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
      if (!rst) begin
        chk("reset_trace_val", 32'(tr.trace_val), 0);
        if (was_rst) begin
          chk("reset_out0", out0, 0);
          chk("reset_out1", out1, 0);
          chk("reset_out2", out2, 0);
        end
        was_rst = 1;
      end else begin
        was_rst = 0;
        chk("trace_val", 32'(tr.trace_val), 1);
        if (tr.trace_val) begin
          chk("commit_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("trace_addr", tr.trace_addr, e.addr);
            chk("trace_inst", tr.trace_inst, e.inst);
            if (e.has_data) chk("trace_data", tr.trace_data, e.data);
            chk("out0", out0, e.o0);
            chk("out1", out1, e.o1);
            chk("out2", out2, e.o2);
            while (spots.size() != 0 && spots[0].idx == n_commit) begin
              case (spots[0].fld)
                0:       chk("spot_addr", tr.trace_addr, spots[0].exp);
                1:       chk("spot_data", tr.trace_data, spots[0].exp);
                default: chk("spot_out0", out0, spots[0].exp);
              endcase
              void'(spots.pop_front());
            end
            n_commit++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

  // stimulus
  initial begin
    int unsigned kind, rd, rs1, rs2, pc;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    set_in(0, 0, 0);
    repeat (3) @(posedge clk);

    // basic lw
    begin_seg();
    put(0, i_addi(1, 0, 'h100)); put(4, i_lw(2, 1, 0)); put('h100, 32'hcafe0123);
    add_spot(0, 0, 32'h0); add_spot(0, 1, 32'h100);
    add_spot(1, 0, 32'h4); add_spot(1, 1, 32'hcafe0123);
    run_seg(2, 0);

    // positive and negative offsets
    begin_seg();
    put(0, i_addi(1, 0, 'h100)); put(4, i_lw(2, 1, 4)); put(8, i_lw(3, 1, -4));
    put('h104, 32'h11); put('hFC, 32'h22);
    add_spot(1, 1, 32'h11); add_spot(2, 1, 32'h22);
    run_seg(3, 0);

    // store then load the same address on the next cycle
    begin_seg();
    set_in(32'hdeadbeef, 0, 0);
    put(0, i_csrr(2, 'hFC2)); put(4, i_addi(1, 0, 'h200));
    put(8, i_sw(2, 1, 0)); put(12, i_lw(3, 1, 0));
    add_spot(3, 1, 32'hdeadbeef);
    run_seg(4, 0);

    // control flow: taken bne, jal, jr back, not-taken bne
    begin_seg();
    put('h00, i_addi(1, 0, 1)); put('h04, i_addi(2, 0, 2));
    put('h08, i_bne(1, 2, 8));  put('h0C, i_addi(5, 0, 5));
    put('h10, i_jal(1, 16));    put('h14, i_addi(6, 0, 7));
    put('h18, i_bne(1, 1, 8));  put('h1C, i_addi(7, 0, 9));
    put('h20, i_jr(1));
    add_spot(3, 0, 32'h10); add_spot(3, 1, 32'h14); add_spot(4, 0, 32'h20);
    add_spot(5, 0, 32'h14); add_spot(7, 0, 32'h1C);
    run_seg(8, 0);

    // I/O round trip
    begin_seg();
    set_in(32'h5, 0, 0);
    put(0, i_csrr(1, 'hFC2)); put(4, i_addi(1, 1, 1));
    put(8, i_csrw('h7C2, 1)); put(12, i_addi(0, 0, 0));
    add_spot(0, 1, 32'h5); add_spot(3, 2, 32'h6);
    run_seg(4, 0);

    // random programs; x31 is a fixed data base at 0x400
    for (int s = 0; s < 12; s++) begin
      begin_seg();
      set_in($urandom, $urandom, $urandom);
      for (int a = 'h3C0; a <= 'h440; a += 4) put(a, $urandom);
      pc = 0;
      for (int r = 1; r < 31; r++) begin
        put(pc, i_addi(r, 0, int'($urandom_range(0, 4095)) - 2048)); pc += 4;
      end
      put(pc, i_addi(31, 0, 'h400)); pc += 4;
      for (int n = 0; n < 40; n++) begin
        kind = $urandom_range(0, 10);
        rd   = $urandom_range(0, 30);
        rs1  = $urandom_range(0, 31);
        rs2  = ($urandom_range(0, 3) == 0) ? rs1 : $urandom_range(0, 31);
        case (kind)
          0:  put(pc, e_r(0, rs2, rs1, rd));
          1:  put(pc, i_addi(rd, rs1, int'($urandom_range(0, 4095)) - 2048));
          2:  put(pc, e_r(1, rs2, rs1, rd));
          3:  put(pc, i_lw(rd, 31, 4 * (int'($urandom_range(0, 32)) - 16)));
          4:  put(pc, i_sw(rs2, 31, 4 * (int'($urandom_range(0, 32)) - 16)));
          5:  put(pc, i_csrr(rd, 'hFC2 + int'($urandom_range(0, 2))));
          6:  put(pc, i_csrw('h7C2 + int'($urandom_range(0, 2)), rs1));
          7:  put(pc, i_bne(rs1, rs2, 4 * int'($urandom_range(2, 3))));
          8:  put(pc, i_jal(rd, 4 * int'($urandom_range(2, 3))));
          9:  put(pc, 32'h0000007F);
          default: put(pc, e_r(0, rs2, rs1, 0));
        endcase
        pc += 4;
      end
      run_seg(0, pc);
    end

    done = 1;
  end
endmodule
